// File: rtl/scan_doubler.sv
// Line doubler: captures each input line into one of two ping-pong buffers and
// replays the previous line twice at double pixel rate on the CLK50M domain.
`timescale 1ns/1ps
module scan_doubler #(
    parameter int unsigned LINE_MAX  = 384,
    parameter int unsigned ODIV      = 4,
    parameter int unsigned OHS_WIDTH = 24
) (
    input  logic        CLK50M,
    input  logic        RESET_N,
    input  logic        PCE,
    input  logic [17:0] IRGB,
    input  logic        IHS,
    input  logic        IVS,
    output logic [17:0] ORGB,
    output logic        OHS,
    output logic        OVS,
    output logic        OCE
);

    localparam int unsigned RGBW = 18;
    localparam int unsigned CW   = $clog2(LINE_MAX + 1);
    localparam int unsigned DW   = (ODIV > 1) ? $clog2(ODIV) : 1;
    localparam int unsigned AW   = $clog2(2 * LINE_MAX);

    typedef enum logic [1:0] {
        PH_FIRST  = 2'd0,
        PH_SECOND = 2'd1,
        PH_IDLE   = 2'd2
    } phase_e;

    logic            ihs_prev_q, ihs_prev_d;
    logic [CW-1:0]   len_q, len_d;
    logic [CW-1:0]   icnt_q, icnt_d;
    logic [CW-1:0]   ocnt_q, ocnt_d;
    logic [DW-1:0]   odiv_q, odiv_d;
    logic            wbank_q, wbank_d;
    logic            rbank_q, rbank_d;
    logic            valid_q, valid_d;
    logic            vslatch_q, vslatch_d;
    phase_e          phase_q, phase_d;

    logic            s1_vld_q;
    logic            s1_hs_q;
    logic            s1_vs_q;
    logic            s1_blank_q;
    logic [RGBW-1:0] rd_data_q;

    logic            hs_edge;
    logic            strobe;
    logic [CW-1:0]   len_new;
    logic            wr_en;
    logic            wr_bank;
    logic [CW-1:0]   wr_ptr;
    logic            rd_bank;
    logic [CW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_addr;
    logic [AW-1:0]   rd_addr;

    logic [RGBW-1:0] mem [2*LINE_MAX];

    assign hs_edge = PCE && !IHS && ihs_prev_q;
    assign len_new = (icnt_q > CW'(LINE_MAX)) ? CW'(LINE_MAX) : icnt_q;

    // A restart coinciding with a divider tick reads address 0 of the new bank.
    assign strobe = (odiv_q == '0) &&
                    (hs_edge ? (len_new != '0) : ((phase_q != PH_IDLE) && (len_q != '0)));

    assign wr_addr = wr_bank ? (AW'(LINE_MAX) + AW'(wr_ptr)) : AW'(wr_ptr);
    assign rd_addr = rd_bank ? (AW'(LINE_MAX) + AW'(rd_ptr)) : AW'(rd_ptr);

    // Next-state logic for capture and replay.
    always_comb begin
        ihs_prev_d = ihs_prev_q;
        len_d      = len_q;
        icnt_d     = icnt_q;
        ocnt_d     = ocnt_q;
        odiv_d     = odiv_q;
        wbank_d    = wbank_q;
        rbank_d    = rbank_q;
        valid_d    = valid_q;
        vslatch_d  = vslatch_q;
        phase_d    = phase_q;
        wr_en      = 1'b0;
        wr_bank    = wbank_q;
        wr_ptr     = icnt_q;
        rd_bank    = rbank_q;
        rd_ptr     = ocnt_q;

        if (PCE) begin
            ihs_prev_d = IHS;
        end

        if (hs_edge) begin
            len_d     = len_new;
            wbank_d   = !wbank_q;
            wr_en     = 1'b1;
            wr_bank   = !wbank_q;
            wr_ptr    = '0;
            icnt_d    = CW'(1);
            vslatch_d = IVS;
            if (len_q != '0) begin
                valid_d = 1'b1;
            end
            rbank_d   = wbank_q;
            rd_bank   = wbank_q;
            rd_ptr    = '0;
            ocnt_d    = '0;
            phase_d   = PH_FIRST;
            odiv_d    = '0;
        end else begin
            if (PCE && (icnt_q < CW'(LINE_MAX))) begin
                wr_en  = 1'b1;
                icnt_d = icnt_q + CW'(1);
            end
            odiv_d = (odiv_q == DW'(ODIV - 1)) ? '0 : odiv_q + DW'(1);
            if (strobe) begin
                if (ocnt_q == len_q - CW'(1)) begin
                    ocnt_d  = '0;
                    phase_d = (phase_q == PH_FIRST) ? PH_SECOND : PH_IDLE;
                end else begin
                    ocnt_d = ocnt_q + CW'(1);
                end
            end
        end
    end

    // Line buffers are not reset; only measured addresses are ever replayed.
    always_ff @(posedge CLK50M) begin
        if (wr_en) begin
            mem[wr_addr] <= IRGB;
        end
        if (strobe) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    always_ff @(posedge CLK50M or negedge RESET_N) begin
        if (!RESET_N) begin
            ihs_prev_q <= 1'b1;
            len_q      <= '0;
            icnt_q     <= '0;
            ocnt_q     <= '0;
            odiv_q     <= '0;
            wbank_q    <= 1'b0;
            rbank_q    <= 1'b0;
            valid_q    <= 1'b0;
            vslatch_q  <= 1'b1;
            phase_q    <= PH_FIRST;
            s1_vld_q   <= 1'b0;
            s1_hs_q    <= 1'b1;
            s1_vs_q    <= 1'b1;
            s1_blank_q <= 1'b1;
            ORGB       <= '0;
            OHS        <= 1'b1;
            OVS        <= 1'b1;
            OCE        <= 1'b0;
        end else begin
            ihs_prev_q <= ihs_prev_d;
            len_q      <= len_d;
            icnt_q     <= icnt_d;
            ocnt_q     <= ocnt_d;
            odiv_q     <= odiv_d;
            wbank_q    <= wbank_d;
            rbank_q    <= rbank_d;
            valid_q    <= valid_d;
            vslatch_q  <= vslatch_d;
            phase_q    <= phase_d;

            // Stage 1 travels alongside the RAM read.
            s1_vld_q   <= strobe;
            if (strobe) begin
                s1_hs_q    <= !(rd_ptr < CW'(OHS_WIDTH));
                s1_vs_q    <= vslatch_d;
                s1_blank_q <= !(valid_d && (len_d != '0));
            end

            // Stage 2: output register; blanks once the doubled pair is done.
            OCE <= s1_vld_q;
            if (s1_vld_q) begin
                ORGB <= s1_blank_q ? '0 : rd_data_q;
                OHS  <= s1_hs_q;
                OVS  <= s1_vs_q;
            end else if (phase_q == PH_IDLE) begin
                ORGB <= '0;
                OHS  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_scan_doubler.sv
// Scoreboard bench for scan_doubler: each HS edge queues the doubled line the
// design should replay; a negedge monitor pops one entry per OCE pulse.
`timescale 1ns/1ps
module tb_scan_doubler;

    localparam int LMAX = 384;

    logic        CLK50M = 1'b0;
    logic        RESET_N;
    logic        PCE;
    logic [17:0] IRGB;
    logic        IHS;
    logic        IVS;
    logic [17:0] ORGB;
    logic        OHS;
    logic        OVS;
    logic        OCE;

    scan_doubler dut (
        .CLK50M (CLK50M),
        .RESET_N(RESET_N),
        .PCE    (PCE),
        .IRGB   (IRGB),
        .IHS    (IHS),
        .IVS    (IVS),
        .ORGB   (ORGB),
        .OHS    (OHS),
        .OVS    (OVS),
        .OCE    (OCE)
    );

    always #10 CLK50M = ~CLK50M;

    typedef struct {
        logic [17:0] rgb;
        logic        hs;
        logic        vs;
        bit          first;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    longint      cyc      = 0;
    longint      last_oce = 0;

    logic [17:0] cur_data [LMAX];
    int          icnt_m;
    int          len_m;
    bit          valid_m;

    always @(posedge CLK50M) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    endtask

    // Monitor: one scoreboard entry per output pixel strobe.
    always @(negedge CLK50M) begin
        if (OCE === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_oce", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pixel", 32'({ORGB, OHS, OVS}), 32'({e.rgb, e.hs, e.vs}));
                if (!e.first) check("oce_gap", 32'(cyc - last_oce), 32'd4);
            end
            last_oce = cyc;
        end
    end

    // Expected replay for the period started by an HS edge; the next edge
    // arrives after n input pixels, i.e. room for 2*n output pixels.
    task automatic edge_model(input logic [17:0] rgb, input logic vs, input int n);
        int ln;
        bit vnew;
        int nout;
        ln   = (icnt_m > LMAX) ? LMAX : icnt_m;
        vnew = valid_m || (len_m != 0);
        nout = (2 * ln < 2 * n) ? 2 * ln : 2 * n;
        for (int k = 0; k < nout; k++) begin
            exp_t e;
            int a;
            a       = k % ln;
            e.rgb   = vnew ? cur_data[a] : 18'd0;
            e.hs    = (a < 24) ? 1'b0 : 1'b1;
            e.vs    = vs;
            e.first = (k == 0);
            exp_q.push_back(e);
        end
        len_m       = ln;
        valid_m     = vnew;
        cur_data[0] = rgb;
        icnt_m      = 1;
    endtask

    task automatic send_pixel(input logic [17:0] rgb, input logic hs, input logic vs);
        @(posedge CLK50M); #1;
        PCE  = 1'b1;
        IRGB = rgb;
        IHS  = hs;
        IVS  = vs;
        @(posedge CLK50M); #1;
        PCE = 1'b0;
        repeat (6) @(posedge CLK50M);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_oce"},  32'(OCE),  32'd0);
        check({tag, "_orgb"}, 32'(ORGB), 32'd0);
        check({tag, "_ohs"},  32'(OHS),  32'd1);
        check({tag, "_ovs"},  32'(OVS),  32'd1);
    endtask

    task automatic do_reset();
        @(posedge CLK50M); #3;
        RESET_N = 1'b0;
        #1;
        check_reset_outputs("midline_rst");
        exp_q.delete();
        icnt_m  = 0;
        len_m   = 0;
        valid_m = 0;
        repeat (3) @(posedge CLK50M);
        @(negedge CLK50M);
        RESET_N = 1'b1;
    endtask

    task automatic send_line(input int tag, input int n, input logic vs,
                             input int idle_at, input int rst_at);
        for (int idx = 0; idx < n; idx++) begin
            logic [17:0] rgb;
            rgb = 18'((tag << 9) | idx);
            if (idx == 0) edge_model(rgb, vs, n);
            else if (icnt_m < LMAX) begin
                cur_data[icnt_m] = rgb;
                icnt_m++;
            end
            send_pixel(rgb, (idx < 24) ? 1'b0 : 1'b1, vs);
            if (idx == idle_at) begin
                #1;
                check("idle_orgb", 32'(ORGB), 32'd0);
                check("idle_ohs",  32'(OHS),  32'd1);
                check("idle_oce",  32'(OCE),  32'd0);
            end
            if (idx == rst_at) do_reset();
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        RESET_N = 1'b1;
        PCE     = 1'b0;
        IRGB    = '0;
        IHS     = 1'b1;
        IVS     = 1'b1;
        icnt_m  = 0;
        len_m   = 0;
        valid_m = 0;
        #5 RESET_N = 1'b0;
        repeat (3) @(posedge CLK50M);
        #1;
        check_reset_outputs("reset");
        @(negedge CLK50M);
        RESET_N = 1'b1;

        // Partial line before the first HS edge: measured but shown black.
        for (int i = 0; i < 100; i++) begin
            cur_data[icnt_m] = 18'(i);
            icnt_m++;
            send_pixel(18'(i), 1'b1, 1'b1);
        end

        send_line(1,  384, 1'b1, -1,  -1);  // first output period black
        send_line(2,  384, 1'b0, -1,  -1);  // replays line 1, OVS low
        send_line(3,  384, 1'b0, -1,  -1);  // replays line 2, OVS low
        send_line(4,  400, 1'b1, -1,  -1);  // replays line 3, OVS high again
        send_line(5,  200, 1'b1, -1,  -1);  // line 4 clamped to 384, period cut short
        send_line(6,  384, 1'b1, 300, -1);  // two 200-pixel lines then idle
        send_line(7,  384, 1'b1, -1,  150); // reset mid-line
        send_line(8,  384, 1'b1, -1,  -1);  // black replay of post-reset remainder
        send_line(9,  384, 1'b1, -1,  -1);  // replays line 8
        send_line(10, 384, 1'b1, -1,  -1);  // replays line 9

        repeat (8) @(posedge CLK50M);
        check("drain", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
